// File: rtl/t03_wb_sram_responder_if.sv
// Wishbone classic-cycle bus bundle between the MMIO master and the SRAM responder.
// ERR_O is present only when T03_WB_RESP_ERR_EN is defined.
interface t03_wb_sram_responder_if;
   logic [31:0] ADR_I;
   logic [31:0] DAT_I;
   logic [3:0]  SEL_I;
   logic        WE_I;
   logic        STB_I;
   logic        CYC_I;
   logic [31:0] DAT_O;
   logic        ACK_O;
`ifdef T03_WB_RESP_ERR_EN
   logic        ERR_O;
`endif

   modport master (
`ifdef T03_WB_RESP_ERR_EN
      input  ERR_O,
`endif
      output ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
      input  DAT_O, ACK_O
   );

   modport slave (
`ifdef T03_WB_RESP_ERR_EN
      output ERR_O,
`endif
      input  ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
      output DAT_O, ACK_O
   );
endinterface

// File: rtl/t03_wb_sram_responder.sv
// Wishbone classic slave backed by a word-addressed register RAM with programmable wait states.
// Define T03_WB_RESP_ERR_EN to answer out-of-range accesses with ERR_O instead of a silent ACK_O.
//
// state   | meaning
// IDLE    | waiting for CYC_I & STB_I; request latched on accept
// WAIT    | counting down wait states; dropped CYC_I/STB_I aborts
// ACK     | one-cycle ACK_O/ERR_O; write lands at the end of this cycle
module t03_wb_sram_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
   parameter int          DEPTH       = 64,
   parameter int          WAIT_STATES = 2
) (
   input logic                     clk,
   input logic                     nrst,
   t03_wb_sram_responder_if.slave  wb
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(4 * DEPTH);
   localparam logic [3:0]  WS   = 4'(WAIT_STATES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic [31:0]     ram [DEPTH];
   logic            lat_we;
   logic            lat_ok;
   logic [AW-1:0]   lat_idx;
   logic [31:0]     lat_dat;
   logic [3:0]      lat_sel;
   logic            ack_q;
   logic [31:0]     dat_q;
`ifdef T03_WB_RESP_ERR_EN
   logic            err_q;
`endif

   logic [31:0]     offset;
   logic            in_range;
   logic            req;
   logic            fire;
   logic            r_ok;
   logic            r_we;
   logic [AW-1:0]   r_idx;

   // With zero wait states the response is launched straight from IDLE on live bus values.
   always_comb begin
      offset   = wb.ADR_I - BASE_ADDR;
      in_range = (wb.ADR_I >= BASE_ADDR) && (offset < SPAN);
      req      = wb.CYC_I & wb.STB_I;
      fire     = 1'b0;
      r_ok     = lat_ok;
      r_we     = lat_we;
      r_idx    = lat_idx;
      if (state == ST_IDLE) begin
         fire  = req && (WS == 4'd0);
         r_ok  = in_range;
         r_we  = wb.WE_I;
         r_idx = offset[AW+1:2];
      end else if (state == ST_WAIT) begin
         fire  = req && (cnt == 4'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         lat_we  <= 1'b0;
         lat_ok  <= 1'b0;
         lat_idx <= '0;
         lat_dat <= 32'd0;
         lat_sel <= 4'd0;
         ack_q   <= 1'b0;
         dat_q   <= 32'd0;
`ifdef T03_WB_RESP_ERR_EN
         err_q   <= 1'b0;
`endif
         for (int i = 0; i < DEPTH; i++) ram[i] <= 32'd0;
      end else begin
         ack_q <= 1'b0;
         dat_q <= 32'd0;
`ifdef T03_WB_RESP_ERR_EN
         err_q <= 1'b0;
`endif
         if (fire) begin
`ifdef T03_WB_RESP_ERR_EN
            ack_q <= r_ok;
            err_q <= !r_ok;
`else
            ack_q <= 1'b1;
`endif
            if (!r_we && r_ok) dat_q <= ram[r_idx];
         end

         case (state)
            ST_IDLE: begin
               if (req) begin
                  lat_we  <= wb.WE_I;
                  lat_ok  <= in_range;
                  lat_idx <= offset[AW+1:2];
                  lat_dat <= wb.DAT_I;
                  lat_sel <= wb.SEL_I;
                  cnt     <= WS;
                  state   <= (WS == 4'd0) ? ST_ACK : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) state <= ST_ACK;
               end
            end
            ST_ACK: begin
               state <= ST_IDLE;
               if (lat_we && lat_ok) begin
                  for (int b = 0; b < 4; b++)
                     if (lat_sel[b]) ram[lat_idx][8*b +: 8] <= lat_dat[8*b +: 8];
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign wb.ACK_O = ack_q;
   assign wb.DAT_O = dat_q;
`ifdef T03_WB_RESP_ERR_EN
   assign wb.ERR_O = err_q;
`endif
endmodule

// File: tb/tb_t03_wb_sram_responder.sv
// Bench for t03_wb_sram_responder: a WAIT_STATES=2 instance for the table and abort/latch
// cases, and a WAIT_STATES=0 instance for back-to-back spacing and mid-transfer reset.
module tb_t03_wb_sram_responder;
   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [31:0] adr = 32'd0;
   logic [31:0] wdat = 32'd0;
   logic [3:0]  sel = 4'd0;
   logic        we = 1'b0;
   logic        stb = 1'b0;
   logic        cyc0 = 1'b0;
   logic        cyc1 = 1'b0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   t03_wb_sram_responder_if wb0 ();
   t03_wb_sram_responder_if wb1 ();

   assign wb0.ADR_I = adr;  assign wb1.ADR_I = adr;
   assign wb0.DAT_I = wdat; assign wb1.DAT_I = wdat;
   assign wb0.SEL_I = sel;  assign wb1.SEL_I = sel;
   assign wb0.WE_I  = we;   assign wb1.WE_I  = we;
   assign wb0.STB_I = stb;  assign wb1.STB_I = stb;
   assign wb0.CYC_I = cyc0; assign wb1.CYC_I = cyc1;

   t03_wb_sram_responder #(.BASE_ADDR(32'h3300_0000), .DEPTH(64), .WAIT_STATES(2))
      dut0 (.clk(clk), .nrst(nrst), .wb(wb0));
   t03_wb_sram_responder #(.BASE_ADDR(32'h3300_0000), .DEPTH(64), .WAIT_STATES(0))
      dut1 (.clk(clk), .nrst(nrst), .wb(wb1));

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        ok;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic sample(input int d, output logic ack, output logic err, output logic [31:0] rd);
      err = 1'b0;
      if (d == 0) begin
         ack = wb0.ACK_O; rd = wb0.DAT_O;
`ifdef T03_WB_RESP_ERR_EN
         err = wb0.ERR_O;
`endif
      end else begin
         ack = wb1.ACK_O; rd = wb1.DAT_O;
`ifdef T03_WB_RESP_ERR_EN
         err = wb1.ERR_O;
`endif
      end
   endtask

   // Called 1 time unit after a rising edge; the next edge accepts the request.
   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic ok, input logic [31:0] exp, input string nm);
      int n;
      logic ga, ge;
      logic [31:0] gd;
      adr = a; wdat = wd; sel = s; we = w; stb = 1'b1;
      if (d == 0) cyc0 = 1'b1; else cyc1 = 1'b1;
      n = 0; ga = 1'b0; ge = 1'b0; gd = 32'd0;
      while (n < 20 && !(ga || ge)) begin
         @(posedge clk); #1;
         n++;
         sample(d, ga, ge, gd);
      end
      stb = 1'b0; cyc0 = 1'b0; cyc1 = 1'b0;
      chk({nm, " latency"}, 32'(n), (d == 0) ? 32'd3 : 32'd1);
`ifdef T03_WB_RESP_ERR_EN
      chk({nm, " ack"}, {31'd0, ga}, {31'd0, ok});
      chk({nm, " err"}, {31'd0, ge}, {31'd0, !ok});
`else
      chk({nm, " ack"}, {31'd0, ga}, 32'd1);
`endif
      if (!w) chk({nm, " rdata"}, gd, exp);
      @(posedge clk); #1;
      sample(d, ga, ge, gd);
      chk({nm, " ack width"}, {30'd0, ga, ge}, 32'd0);
      chk({nm, " dat idle"}, gd, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic ga, ge;
      logic [31:0] gd;
      int seen;

      vt[0]  = '{1'b0, 32'h3300_0010, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
      vt[1]  = '{1'b1, 32'h3300_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0};
      vt[2]  = '{1'b0, 32'h3300_0004, 32'h0,         4'hF, 1'b1, 32'hDEAD_BEEF};
      vt[3]  = '{1'b1, 32'h3300_0004, 32'h1122_3344, 4'h5, 1'b1, 32'h0};
      vt[4]  = '{1'b0, 32'h3300_0004, 32'h0,         4'h0, 1'b1, 32'hDE22_BE44};
      vt[5]  = '{1'b1, 32'h3300_00FC, 32'hA5A5_A5A5, 4'hF, 1'b1, 32'h0};
      vt[6]  = '{1'b0, 32'h3300_00FC, 32'h0,         4'hF, 1'b1, 32'hA5A5_A5A5};
      vt[7]  = '{1'b1, 32'h3300_0000, 32'h1234_5678, 4'h0, 1'b1, 32'h0};
      vt[8]  = '{1'b0, 32'h3300_0000, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
      vt[9]  = '{1'b0, 32'h3300_0100, 32'h0,         4'hF, 1'b0, 32'h0000_0000};
      vt[10] = '{1'b1, 32'h32FF_FFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
      vt[11] = '{1'b0, 32'h3300_00FC, 32'h0,         4'hF, 1'b1, 32'hA5A5_A5A5};
      vt[12] = '{1'b0, 32'h3300_0007, 32'h0,         4'hF, 1'b1, 32'hDE22_BE44};

      repeat (3) @(posedge clk);
      #1;
      sample(0, ga, ge, gd);
      chk("reset dut0 ack/err", {30'd0, ga, ge}, 32'd0);
      chk("reset dut0 dat", gd, 32'd0);
      nrst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++)
         xfer(0, vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].ok, vt[i].exp, $sformatf("vec%0d", i));

      // Abort: drop CYC_I while the write is still waiting.
      adr = 32'h3300_0008; wdat = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc0 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc0 = 1'b0; stb = 1'b0;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         sample(0, ga, ge, gd);
         if (ga || ge) seen++;
      end
      chk("abort no ack", 32'(seen), 32'd0);
      xfer(0, 1'b0, 32'h3300_0008, 32'h0, 4'hF, 1'b1, 32'h0, "abort readback");

      // Address and direction changes after accept are ignored.
      adr = 32'h3300_0004; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc0 = 1'b1;
      @(posedge clk); #1;
      adr = 32'h3300_0010; we = 1'b1; wdat = 32'h5555_5555;
      seen = 0; ga = 1'b0; ge = 1'b0;
      while (seen < 10 && !ga) begin
         @(posedge clk); #1;
         seen++;
         sample(0, ga, ge, gd);
      end
      cyc0 = 1'b0; stb = 1'b0;
      chk("latched ack", {31'd0, ga}, 32'd1);
      chk("latched rdata", gd, 32'hDE22_BE44);
      @(posedge clk); #1;
      xfer(0, 1'b0, 32'h3300_0010, 32'h0, 4'hF, 1'b1, 32'h0, "latched no write");

      // STB_I without CYC_I is not a request.
      adr = 32'h3300_0000; wdat = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc0 = 1'b0;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         sample(0, ga, ge, gd);
         if (ga || ge) seen++;
      end
      stb = 1'b0;
      chk("stb no cyc", 32'(seen), 32'd0);
      xfer(0, 1'b0, 32'h3300_0000, 32'h0, 4'hF, 1'b1, 32'h0, "stb no cyc readback");

      // Zero-wait instance: back-to-back reads with STB held.
      xfer(1, 1'b1, 32'h3300_0000, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0, "ws0 wr0");
      xfer(1, 1'b1, 32'h3300_0004, 32'h0BAD_BEEF, 4'hF, 1'b1, 32'h0, "ws0 wr1");
      adr = 32'h3300_0000; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc1 = 1'b1;
      @(posedge clk); #1;
      sample(1, ga, ge, gd);
      chk("b2b ack1", {31'd0, ga}, 32'd1);
      chk("b2b dat1", gd, 32'hCAFE_F00D);
      adr = 32'h3300_0004;
      @(posedge clk); #1;
      sample(1, ga, ge, gd);
      chk("b2b gap", {31'd0, ga}, 32'd0);
      @(posedge clk); #1;
      sample(1, ga, ge, gd);
      chk("b2b ack2", {31'd0, ga}, 32'd1);
      chk("b2b dat2", gd, 32'h0BAD_BEEF);
      cyc1 = 1'b0; stb = 1'b0;
      @(posedge clk); #1;

      // Reset lands on the edge that would accept the second request.
      adr = 32'h3300_0000; stb = 1'b1; cyc1 = 1'b1;
      @(posedge clk); #1;
      sample(1, ga, ge, gd);
      chk("rst seq ack1", {31'd0, ga}, 32'd1);
      @(posedge clk); #1;
      nrst = 1'b0;
      @(posedge clk); #1;
      sample(1, ga, ge, gd);
      chk("rst abort ack", {30'd0, ga, ge}, 32'd0);
      chk("rst abort dat", gd, 32'd0);
      nrst = 1'b1; cyc1 = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      xfer(1, 1'b0, 32'h3300_0000, 32'h0, 4'hF, 1'b1, 32'h0, "rst cleared w0");
      xfer(1, 1'b0, 32'h3300_0004, 32'h0, 4'hF, 1'b1, 32'h0, "rst cleared w1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
